debug_lsa_trig: RTL

//  Parametrised single-clock logic state analyzer, the successor to the fixed
//  32x1024 LSA. Captures DATA_W-bit samples into a DEPTH-entry circular buffer.

---
 rtl/debug_lsa_pkg.sv | 28 ++
 rtl/debug_lsa_ram.sv | 24 ++
 rtl/debug_lsa_trig.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_lsa_pkg.sv
// Shared definitions for the logic state analyzer: register map, CTRL bit
// positions and capture FSM encoding.
package debug_lsa_pkg;

  localparam int REG_CTRL    = 0;
  localparam int REG_LIVE    = 1;
  localparam int REG_MASK    = 2;
  localparam int REG_VALUE   = 3;
  localparam int REG_PRE     = 4;
  localparam int REG_TRIGPTR = 5;

  localparam int CTRL_ARM       = 0;
  localparam int CTRL_FORCE     = 1;
  localparam int CTRL_DONE      = 2;
  localparam int CTRL_RUNNING   = 3;
  localparam int CTRL_TRIGGERED = 4;
  localparam int CTRL_EXT_EN    = 5;
  localparam int CTRL_MODE_LSB  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } lsa_state_t;

endpackage

// File: rtl/debug_lsa_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module debug_lsa_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/debug_lsa_trig.sv
// Parametrised logic state analyzer with pre-trigger window, pattern, external
// and forced triggers, on an Avalon-MM slave with chronological readback.
module debug_lsa_trig
  import debug_lsa_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         DEPTH_LOG2  = 10,
  parameter logic       INIT_ARMED  = 1'b1,
  parameter logic       INIT_FORCED = 1'b0,
  parameter logic [7:0] INIT_MODE   = 8'd0
) (
  input  logic                  av_clk,
  input  logic                  av_rst,
  input  logic [DEPTH_LOG2:0]   av_address,
  input  logic                  av_write,
  input  logic                  av_read,
  input  logic [31:0]           av_writedata,
  output logic [31:0]           av_readdata,
  output logic                  av_readdatavalid,
  output logic [7:0]            lsa_mode,
  input  logic                  lsa_valid,
  input  logic                  lsa_trigger,
  input  logic [DATA_W-1:0]     lsa_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] ONE      = DEPTH_LOG2'(1);

  logic                  ctrl_arm, ctrl_force, ctrl_ext_en;
  logic [7:0]            ctrl_mode;
  logic [DATA_W-1:0]     mask_reg, value_reg, live_q;
  logic [DEPTH_LOG2-1:0] pre_reg;

  logic [DATA_W-1:0]     mask_q, value_q;
  logic [DEPTH_LOG2-1:0] pre_q, wr_ptr, count_q, trig_ptr;
  logic                  triggered;

  lsa_state_t            state_q, state_d;
  logic                  start, cap_we, trig_now;

  logic                  is_ram, reg_wr, ctrl_wr, arm_clear;
  logic [DEPTH_LOG2-1:0] reg_off, post_len, rd_addr;
  logic                  pat_hit, hit, running, done;
  logic [31:0]           reg_rdata, rd_reg_q;
  logic                  rd_ram_q;
  logic [DATA_W-1:0]     ram_rdata;

  assign is_ram    = av_address[DEPTH_LOG2];
  assign reg_off   = av_address[DEPTH_LOG2-1:0];
  assign reg_wr    = av_write & ~is_ram;
  assign ctrl_wr   = reg_wr && (reg_off == DEPTH_LOG2'(REG_CTRL));
  assign arm_clear = ctrl_wr & ~av_writedata[CTRL_ARM];

  // Pattern trigger uses the copies latched at arm time; force/ext_en are live.
  assign pat_hit  = (mask_q != '0) && (((lsa_data ^ value_q) & mask_q) == '0);
  assign hit      = ctrl_force | (ctrl_ext_en & lsa_trigger) | pat_hit;
  assign post_len = LAST_IDX - pre_q;
  assign running  = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign done     = (state_q == ST_DONE);
  assign lsa_mode = ctrl_mode;

  always_ff @(posedge av_clk or posedge av_rst) begin
    if (av_rst) begin
      ctrl_arm    <= INIT_ARMED;
      ctrl_force  <= INIT_FORCED;
      ctrl_ext_en <= 1'b0;
      ctrl_mode   <= INIT_MODE;
      mask_reg    <= '0;
      value_reg   <= '0;
      pre_reg     <= '0;
      live_q      <= '0;
    end else begin
      live_q <= lsa_data;
      if (reg_wr) begin
        case (reg_off)
          DEPTH_LOG2'(REG_CTRL): begin
            ctrl_arm    <= av_writedata[CTRL_ARM];
            ctrl_force  <= av_writedata[CTRL_FORCE];
            ctrl_ext_en <= av_writedata[CTRL_EXT_EN];
            ctrl_mode   <= av_writedata[CTRL_MODE_LSB +: 8];
          end
          DEPTH_LOG2'(REG_MASK):  mask_reg  <= av_writedata[DATA_W-1:0];
          DEPTH_LOG2'(REG_VALUE): value_reg <= av_writedata[DATA_W-1:0];
          DEPTH_LOG2'(REG_PRE):
            pre_reg <= (av_writedata > 32'(DEPTH - 1)) ? LAST_IDX
                                                       : av_writedata[DEPTH_LOG2-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge av_clk or posedge av_rst) begin
    if (av_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture sequencing; everything except the arm start waits for lsa_valid.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    cap_we   = 1'b0;
    trig_now = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_arm) begin
          start   = 1'b1;
          state_d = (pre_reg == '0) ? ST_WAIT : ST_PRE;
        end
      end
      ST_PRE: begin
        if (lsa_valid) begin
          cap_we = 1'b1;
          if ((count_q + ONE) == pre_q) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lsa_valid) begin
          cap_we = 1'b1;
          if (hit) begin
            trig_now = 1'b1;
            state_d  = (post_len == '0) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (lsa_valid) begin
          cap_we = 1'b1;
          if (count_q == ONE) state_d = ST_DONE;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (arm_clear) begin
      state_d  = ST_IDLE;
      start    = 1'b0;
      cap_we   = 1'b0;
      trig_now = 1'b0;
    end
  end

  always_ff @(posedge av_clk or posedge av_rst) begin
    if (av_rst) begin
      mask_q    <= '0;
      value_q   <= '0;
      pre_q     <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      trig_ptr  <= '0;
      triggered <= 1'b0;
    end else if (start) begin
      mask_q    <= mask_reg;
      value_q   <= value_reg;
      pre_q     <= pre_reg;
      wr_ptr    <= '0;
      count_q   <= '0;
      triggered <= 1'b0;
    end else if (cap_we) begin
      wr_ptr <= wr_ptr + ONE;
      if (state_q == ST_PRE) begin
        count_q <= count_q + ONE;
      end else if (state_q == ST_POST) begin
        count_q <= count_q - ONE;
      end else if (trig_now) begin
        count_q   <= post_len;
        trig_ptr  <= wr_ptr;
        triggered <= 1'b1;
      end
    end
  end

  // Sample index 0 is the oldest pre-trigger sample; index PRE is the trigger.
  assign rd_addr = trig_ptr - pre_q + reg_off;

  debug_lsa_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (av_clk),
    .we    (cap_we),
    .waddr (wr_ptr),
    .wdata (lsa_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      DEPTH_LOG2'(REG_CTRL): begin
        reg_rdata[CTRL_ARM]             = ctrl_arm;
        reg_rdata[CTRL_FORCE]           = ctrl_force;
        reg_rdata[CTRL_DONE]            = done;
        reg_rdata[CTRL_RUNNING]         = running;
        reg_rdata[CTRL_TRIGGERED]       = triggered;
        reg_rdata[CTRL_EXT_EN]          = ctrl_ext_en;
        reg_rdata[CTRL_MODE_LSB +: 8]   = ctrl_mode;
      end
      DEPTH_LOG2'(REG_LIVE):    reg_rdata = 32'(live_q);
      DEPTH_LOG2'(REG_MASK):    reg_rdata = 32'(mask_reg);
      DEPTH_LOG2'(REG_VALUE):   reg_rdata = 32'(value_reg);
      DEPTH_LOG2'(REG_PRE):     reg_rdata = 32'(pre_reg);
      DEPTH_LOG2'(REG_TRIGPTR): reg_rdata = 32'(trig_ptr);
      default: ;
    endcase
  end

  always_ff @(posedge av_clk or posedge av_rst) begin
    if (av_rst) begin
      av_readdatavalid <= 1'b0;
      rd_ram_q         <= 1'b0;
      rd_reg_q         <= '0;
    end else begin
      av_readdatavalid <= av_read;
      rd_ram_q         <= av_read & is_ram;
      rd_reg_q         <= (av_read & ~is_ram) ? reg_rdata : '0;
    end
  end

  assign av_readdata = rd_ram_q ? 32'(ram_rdata) : rd_reg_q;

endmodule
